// File: rtl/mpf_vtp_pt_host_arb.sv
// Page-table walker host port arbiter: N_REQ requesters share one host read and one host write port.
// Define MPF_VTP_PT_HOST_ARB_STATS_EN to build the per-requester saturating read grant counters.
module mpf_vtp_pt_host_arb #(
    parameter int N_REQ        = 2,
    parameter int CL_ADDR_BITS = 42,
    parameter int CL_DATA_BITS = 512,
    parameter int MDATA_BITS   = 16,
    parameter int WR_DATA_BITS = 64,
    parameter int IDX_BITS     = $clog2(N_REQ),
    parameter int UP_TAG_BITS  = MDATA_BITS - IDX_BITS
) (
    input  logic                                     clk,
    input  logic                                     reset,

    input  logic [N_REQ-1:0]                         up_readEn,
    input  logic [N_REQ-1:0][CL_ADDR_BITS-1:0]       up_readAddr,
    input  logic [N_REQ-1:0][UP_TAG_BITS-1:0]        up_readReqTag,
    output logic [N_REQ-1:0]                         up_readRdy,
    output logic [N_REQ-1:0]                         up_readDataEn,
    output logic [CL_DATA_BITS-1:0]                  up_readData,
    output logic [UP_TAG_BITS-1:0]                   up_readRspTag,

    input  logic [N_REQ-1:0]                         up_writeEn,
    input  logic [N_REQ-1:0][CL_ADDR_BITS-1:0]       up_writeAddr,
    input  logic [N_REQ-1:0][WR_DATA_BITS-1:0]       up_writeData,
    output logic [N_REQ-1:0]                         up_writeRdy,

    output logic                                     dn_readEn,
    output logic [CL_ADDR_BITS-1:0]                  dn_readAddr,
    output logic [MDATA_BITS-1:0]                    dn_readReqTag,
    input  logic                                     dn_readRdy,
    input  logic                                     dn_readDataEn,
    input  logic [CL_DATA_BITS-1:0]                  dn_readData,
    input  logic [MDATA_BITS-1:0]                    dn_readRspTag,

    output logic                                     dn_writeEn,
    output logic [CL_ADDR_BITS-1:0]                  dn_writeAddr,
    output logic [WR_DATA_BITS-1:0]                  dn_writeData,
    input  logic                                     dn_writeRdy,

    output logic [N_REQ-1:0][31:0]                   stat_readGrants
);

    localparam int unsigned NR = N_REQ;

    if (N_REQ != 2 && N_REQ != 4) begin : gBadNReq
        $error("mpf_vtp_pt_host_arb: N_REQ must be 2 or 4");
    end

    // Returns {found, index}; search begins one past the previous winner.
    function automatic logic [IDX_BITS:0] rrPick(input logic [N_REQ-1:0] valid,
                                                 input logic [IDX_BITS-1:0] last);
        logic [IDX_BITS:0] pick;
        logic              found;
        int unsigned       cand;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand = (32'(last) + k) % NR;
            if (!found && valid[IDX_BITS'(cand)]) begin
                found = 1'b1;
                pick  = {1'b1, IDX_BITS'(cand)};
            end
        end
        return pick;
    endfunction

    logic [N_REQ-1:0]                   rdValid, wrValid;
    logic [N_REQ-1:0][CL_ADDR_BITS-1:0] rdAddr, wrAddr;
    logic [N_REQ-1:0][UP_TAG_BITS-1:0]  rdTag;
    logic [N_REQ-1:0][WR_DATA_BITS-1:0] wrData;
    logic [IDX_BITS-1:0]                rdPtr, wrPtr;
    logic [IDX_BITS:0]                  rdPick, wrPick;
    logic [N_REQ-1:0]                   rdGrant, wrGrant;
    logic [IDX_BITS-1:0]                rdIdx, wrIdx;

    always_comb begin
        rdPick  = rrPick(rdValid & {N_REQ{dn_readRdy}}, rdPtr);
        wrPick  = rrPick(wrValid & {N_REQ{dn_writeRdy}}, wrPtr);
        rdIdx   = rdPick[IDX_BITS-1:0];
        wrIdx   = wrPick[IDX_BITS-1:0];
        rdGrant = rdPick[IDX_BITS] ? (N_REQ'(1) << rdIdx) : '0;
        wrGrant = wrPick[IDX_BITS] ? (N_REQ'(1) << wrIdx) : '0;
    end

    // A buffer being granted this cycle can accept a new request on the same edge.
    assign up_readRdy  = ~rdValid | rdGrant;
    assign up_writeRdy = ~wrValid | wrGrant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdValid       <= '0;
            rdAddr        <= '0;
            rdTag         <= '0;
            rdPtr         <= IDX_BITS'(N_REQ - 1);
            dn_readEn     <= 1'b0;
            dn_readAddr   <= '0;
            dn_readReqTag <= '0;
        end else begin
            dn_readEn <= rdPick[IDX_BITS];
            if (rdPick[IDX_BITS]) begin
                rdPtr         <= rdIdx;
                dn_readAddr   <= rdAddr[rdIdx];
                dn_readReqTag <= {rdIdx, rdTag[rdIdx]};
            end
            for (int unsigned i = 0; i < NR; i++) begin
                if (up_readEn[i]) begin
                    rdValid[i] <= 1'b1;
                    rdAddr[i]  <= up_readAddr[i];
                    rdTag[i]   <= up_readReqTag[i];
                end else if (rdGrant[i]) begin
                    rdValid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrValid      <= '0;
            wrAddr       <= '0;
            wrData       <= '0;
            wrPtr        <= IDX_BITS'(N_REQ - 1);
            dn_writeEn   <= 1'b0;
            dn_writeAddr <= '0;
            dn_writeData <= '0;
        end else begin
            dn_writeEn <= wrPick[IDX_BITS];
            if (wrPick[IDX_BITS]) begin
                wrPtr        <= wrIdx;
                dn_writeAddr <= wrAddr[wrIdx];
                dn_writeData <= wrData[wrIdx];
            end
            for (int unsigned i = 0; i < NR; i++) begin
                if (up_writeEn[i]) begin
                    wrValid[i] <= 1'b1;
                    wrAddr[i]  <= up_writeAddr[i];
                    wrData[i]  <= up_writeData[i];
                end else if (wrGrant[i]) begin
                    wrValid[i] <= 1'b0;
                end
            end
        end
    end

    // Response routing: the top tag bits name the requester, the rest return upstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_readDataEn <= '0;
            up_readData   <= '0;
            up_readRspTag <= '0;
        end else begin
            for (int unsigned i = 0; i < NR; i++) begin
                up_readDataEn[i] <= dn_readDataEn &&
                                    (dn_readRspTag[MDATA_BITS-1 -: IDX_BITS] == IDX_BITS'(i));
            end
            if (dn_readDataEn) begin
                up_readData   <= dn_readData;
                up_readRspTag <= dn_readRspTag[UP_TAG_BITS-1:0];
            end
        end
    end

`ifdef MPF_VTP_PT_HOST_ARB_STATS_EN
    logic [N_REQ-1:0][31:0] statCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            statCnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NR; i++) begin
                if (rdGrant[i] && (statCnt[i] != '1)) begin
                    statCnt[i] <= statCnt[i] + 32'd1;
                end
            end
        end
    end

    assign stat_readGrants = statCnt;
`else
    assign stat_readGrants = '0;
`endif

endmodule

// File: tb/tb_mpf_vtp_pt_host_arb.sv
// Directed self-checking bench for mpf_vtp_pt_host_arb with default parameters (N_REQ=2).
module tb_mpf_vtp_pt_host_arb;

    localparam int N_REQ        = 2;
    localparam int CL_ADDR_BITS = 42;
    localparam int CL_DATA_BITS = 512;
    localparam int MDATA_BITS   = 16;
    localparam int WR_DATA_BITS = 64;
    localparam int UP_TAG_BITS  = 15;

    logic                                clk = 1'b0;
    logic                                reset;
    logic [N_REQ-1:0]                    up_readEn;
    logic [N_REQ-1:0][CL_ADDR_BITS-1:0]  up_readAddr;
    logic [N_REQ-1:0][UP_TAG_BITS-1:0]   up_readReqTag;
    logic [N_REQ-1:0]                    up_readRdy;
    logic [N_REQ-1:0]                    up_readDataEn;
    logic [CL_DATA_BITS-1:0]             up_readData;
    logic [UP_TAG_BITS-1:0]              up_readRspTag;
    logic [N_REQ-1:0]                    up_writeEn;
    logic [N_REQ-1:0][CL_ADDR_BITS-1:0]  up_writeAddr;
    logic [N_REQ-1:0][WR_DATA_BITS-1:0]  up_writeData;
    logic [N_REQ-1:0]                    up_writeRdy;
    logic                                dn_readEn;
    logic [CL_ADDR_BITS-1:0]             dn_readAddr;
    logic [MDATA_BITS-1:0]               dn_readReqTag;
    logic                                dn_readRdy;
    logic                                dn_readDataEn;
    logic [CL_DATA_BITS-1:0]             dn_readData;
    logic [MDATA_BITS-1:0]               dn_readRspTag;
    logic                                dn_writeEn;
    logic [CL_ADDR_BITS-1:0]             dn_writeAddr;
    logic [WR_DATA_BITS-1:0]             dn_writeData;
    logic                                dn_writeRdy;
    logic [N_REQ-1:0][31:0]              stat_readGrants;

    int checks   = 0;
    int failures = 0;

`ifdef MPF_VTP_PT_HOST_ARB_STATS_EN
    localparam logic [31:0] EXP_STAT0_AFTER_TWO = 32'd2;
`else
    localparam logic [31:0] EXP_STAT0_AFTER_TWO = 32'd0;
`endif

    mpf_vtp_pt_host_arb #(
        .N_REQ(N_REQ),
        .CL_ADDR_BITS(CL_ADDR_BITS),
        .CL_DATA_BITS(CL_DATA_BITS),
        .MDATA_BITS(MDATA_BITS),
        .WR_DATA_BITS(WR_DATA_BITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .up_readEn(up_readEn),
        .up_readAddr(up_readAddr),
        .up_readReqTag(up_readReqTag),
        .up_readRdy(up_readRdy),
        .up_readDataEn(up_readDataEn),
        .up_readData(up_readData),
        .up_readRspTag(up_readRspTag),
        .up_writeEn(up_writeEn),
        .up_writeAddr(up_writeAddr),
        .up_writeData(up_writeData),
        .up_writeRdy(up_writeRdy),
        .dn_readEn(dn_readEn),
        .dn_readAddr(dn_readAddr),
        .dn_readReqTag(dn_readReqTag),
        .dn_readRdy(dn_readRdy),
        .dn_readDataEn(dn_readDataEn),
        .dn_readData(dn_readData),
        .dn_readRspTag(dn_readRspTag),
        .dn_writeEn(dn_writeEn),
        .dn_writeAddr(dn_writeAddr),
        .dn_writeData(dn_writeData),
        .dn_writeRdy(dn_writeRdy),
        .stat_readGrants(stat_readGrants)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset         = 1'b1;
        up_readEn     = '0;
        up_writeEn    = '0;
        dn_readDataEn = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        up_readEn     = '0;
        up_readAddr   = '0;
        up_readReqTag = '0;
        up_writeEn    = '0;
        up_writeAddr  = '0;
        up_writeData  = '0;
        dn_readRdy    = 1'b1;
        dn_writeRdy   = 1'b1;
        dn_readDataEn = 1'b0;
        dn_readData   = '0;
        dn_readRspTag = '0;
        #1;
        doReset();

        // Reset state
        chk("rst_dnReadEn",   512'(dn_readEn), 512'd0);
        chk("rst_dnWriteEn",  512'(dn_writeEn), 512'd0);
        chk("rst_upDataEn",   512'(up_readDataEn), 512'd0);
        chk("rst_upReadRdy",  512'(up_readRdy), 512'h3);
        chk("rst_upWriteRdy", 512'(up_writeRdy), 512'h3);
        chk("rst_stat",       512'(stat_readGrants), 512'd0);

        // Requester 0 back-to-back reads, tags 5 and 6
        up_readEn        = 2'b01;
        up_readAddr[0]   = 42'h100;
        up_readReqTag[0] = 15'h5;
        step();
        chk("lat_c1_dnReadEn", 512'(dn_readEn), 512'd0);
        chk("lat_c1_upReadRdy", 512'(up_readRdy[0]), 512'd1);
        up_readAddr[0]   = 42'h101;
        up_readReqTag[0] = 15'h6;
        step();
        up_readEn = '0;
        chk("lat_c2_dnReadEn", 512'(dn_readEn), 512'd1);
        chk("lat_c2_tag",      512'(dn_readReqTag), 512'h0005);
        chk("lat_c2_addr",     512'(dn_readAddr), 512'h100);
        step();
        chk("lat_c3_dnReadEn", 512'(dn_readEn), 512'd1);
        chk("lat_c3_tag",      512'(dn_readReqTag), 512'h0006);
        chk("lat_c3_addr",     512'(dn_readAddr), 512'h101);
        step();
        chk("lat_c4_dnReadEn", 512'(dn_readEn), 512'd0);
        chk("stat_req0",       512'(stat_readGrants[0]), 512'(EXP_STAT0_AFTER_TWO));
        chk("stat_req1",       512'(stat_readGrants[1]), 512'd0);

        // Both requesters continuously reading: grants alternate 0,1,0,1
        doReset();
        up_readReqTag[0] = 15'h11;
        up_readReqTag[1] = 15'h22;
        for (int c = 0; c < 6; c++) begin
            up_readEn = up_readRdy;
            step();
            if (c >= 1 && c <= 4) begin
                chk("rr_dnReadEn", 512'(dn_readEn), 512'd1);
                chk("rr_tag", 512'(dn_readReqTag), ((c % 2) == 1) ? 512'h0011 : 512'h8022);
            end
        end
        up_readEn = '0;

        // Read backpressure for 5 cycles, then release
        doReset();
        dn_readRdy = 1'b0;
        up_readEn  = 2'b11;
        up_readReqTag[0] = 15'h1;
        up_readReqTag[1] = 15'h2;
        step();
        up_readEn = '0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_dnReadEn",  512'(dn_readEn), 512'd0);
            chk("bp_upReadRdy", 512'(up_readRdy), 512'd0);
            step();
        end
        chk("bp_last_dnReadEn", 512'(dn_readEn), 512'd0);
        dn_readRdy = 1'b1;
        #1;
        chk("bp_rel_upReadRdy", 512'(up_readRdy), 512'h1);
        step();
        chk("bp_rel_g0_en",  512'(dn_readEn), 512'd1);
        chk("bp_rel_g0_tag", 512'(dn_readReqTag), 512'h0001);
        step();
        chk("bp_rel_g1_en",  512'(dn_readEn), 512'd1);
        chk("bp_rel_g1_tag", 512'(dn_readReqTag), 512'h8002);
        step();
        chk("bp_rel_done", 512'(dn_readEn), 512'd0);

        // Response routing
        dn_readDataEn = 1'b1;
        dn_readRspTag = 16'h802A;
        dn_readData   = {8{64'hA5A5_0000_1234_5678}};
        step();
        dn_readDataEn = 1'b0;
        dn_readData   = '0;
        chk("rsp1_dataEn", 512'(up_readDataEn), 512'h2);
        chk("rsp1_tag",    512'(up_readRspTag), 512'h2A);
        chk("rsp1_data",   up_readData, {8{64'hA5A5_0000_1234_5678}});
        step();
        chk("rsp1_off", 512'(up_readDataEn), 512'd0);
        dn_readDataEn = 1'b1;
        dn_readRspTag = 16'h0003;
        step();
        dn_readDataEn = 1'b0;
        chk("rsp0_dataEn", 512'(up_readDataEn), 512'h1);
        chk("rsp0_tag",    512'(up_readRspTag), 512'h3);

        // Simultaneous read and write from requester 1
        doReset();
        up_readEn        = 2'b10;
        up_readAddr[1]   = 42'h123;
        up_readReqTag[1] = 15'h7;
        up_writeEn       = 2'b10;
        up_writeAddr[1]  = 42'h456;
        up_writeData[1]  = 64'hDEAD_BEEF_0000_0001;
        step();
        up_readEn  = '0;
        up_writeEn = '0;
        step();
        chk("rw_dnReadEn",   512'(dn_readEn), 512'd1);
        chk("rw_dnWriteEn",  512'(dn_writeEn), 512'd1);
        chk("rw_readTag",    512'(dn_readReqTag), 512'h8007);
        chk("rw_readAddr",   512'(dn_readAddr), 512'h123);
        chk("rw_writeAddr",  512'(dn_writeAddr), 512'h456);
        chk("rw_writeData",  512'(dn_writeData), 512'hDEAD_BEEF_0000_0001);
        step();
        chk("rw_off", 512'({dn_readEn, dn_writeEn}), 512'd0);

        // Write arbiter with backpressure
        dn_writeRdy     = 1'b0;
        up_writeEn      = 2'b11;
        up_writeAddr[0] = 42'hA0;
        up_writeAddr[1] = 42'hA1;
        step();
        up_writeEn = '0;
        step();
        chk("wbp_rdy",  512'(up_writeRdy), 512'd0);
        chk("wbp_en",   512'(dn_writeEn), 512'd0);
        dn_writeRdy = 1'b1;
        #1;
        chk("wbp_rel_rdy", 512'(up_writeRdy), 512'h1);
        step();
        chk("wbp_g0", 512'({dn_writeEn, dn_writeAddr}), {470'd0, 1'b1, 42'hA0});
        step();
        chk("wbp_g1", 512'({dn_writeEn, dn_writeAddr}), {470'd0, 1'b1, 42'hA1});
        step();
        chk("wbp_done", 512'(dn_writeEn), 512'd0);

        // Reset with both read buffers valid; a response during reset is dropped
        doReset();
        dn_readRdy       = 1'b0;
        up_readEn        = 2'b11;
        step();
        up_readEn = '0;
        step();
        chk("rr_full_rdy", 512'(up_readRdy), 512'd0);
        reset         = 1'b1;
        dn_readDataEn = 1'b1;
        dn_readRspTag = 16'h8001;
        step();
        dn_readDataEn = 1'b0;
        chk("rst_rsp_dropped", 512'(up_readDataEn), 512'd0);
        reset      = 1'b0;
        dn_readRdy = 1'b1;
        #1;
        chk("rst_flush_rdy", 512'(up_readRdy), 512'h3);
        step();
        chk("rst_flush_en1", 512'(dn_readEn), 512'd0);
        chk("rst_flush_dataEn", 512'(up_readDataEn), 512'd0);
        step();
        chk("rst_flush_en2", 512'(dn_readEn), 512'd0);
        chk("rst_flush_stat", 512'(stat_readGrants), 512'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
